// File: rtl/fpu_sp_pkg.sv
// Shared definitions for the single-precision add/sub request sequencer.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
// Contents: operation codes, the canonical quiet NaN, FSM state encoding.
package fpu_sp_pkg;

    localparam logic        OP_ADD  = 1'b0;
    localparam logic        OP_SUB  = 1'b1;
    localparam logic [31:0] FP_QNAN = 32'h7FC00000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/fpu_sp_req_fifo.sv
// In-order request buffer, WIDTH bits by DEPTH entries, head visible combinationally on dout.
// Latency: a push is visible at dout the cycle after it is written.
// Backpressure: pushes while full and pops while empty are ignored; full/empty exposed to the caller.
// Ports: clk, rst (async, active-high), push/din, pop/dout, full, empty.
module fpu_sp_req_fifo #(
    parameter int WIDTH = 69,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty when the indices match.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/fpu_sp_issue.sv
// Sequences tagged add/sub requests one at a time into the FP add unit and returns tagged results.
// Latency: request handshake to rsp_valid is unit latency + 3 cycles (minimum 4); watchdog caps the wait.
// Backpressure: req_ready = !full; a pending response holds the FSM in RESP until rsp_ready.
// Ports: req_* (valid/ready request in), rsp_* (valid/ready response out), fu_* (unit dval/rdy side), busy.
module fpu_sp_issue
    import fpu_sp_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_op,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err,
    output logic             fu_dval,
    output logic             fu_op,
    output logic [31:0]      fu_din1,
    output logic [31:0]      fu_din2,
    input  logic [31:0]      fu_result,
    input  logic             fu_rdy,
    output logic             busy
);

    localparam int              FW      = 1 + 64 + TAG_W;
    localparam int              CW      = $clog2(TIMEOUT);
    localparam logic [CW-1:0]   WD_LAST = CW'(TIMEOUT - 1);

    state_t           state;
    state_t           state_nxt;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic [FW-1:0]    fifo_dout;
    logic             head_op;
    logic [31:0]      head_a;
    logic [31:0]      head_b;
    logic [TAG_W-1:0] head_tag;
    logic             iss_op;
    logic [31:0]      iss_a;
    logic [31:0]      iss_b;
    logic [TAG_W-1:0] iss_tag;
    logic [CW-1:0]    wd_cnt;
    logic             wd_fire;

    assign req_ready = !fifo_full;

    fpu_sp_req_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_req_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (req_valid && !fifo_full),
        .din   ({req_op, req_a, req_b, req_tag}),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign {head_op, head_a, head_b, head_tag} = fifo_dout;

    // fu_rdy takes priority over the watchdog when both land on the same cycle.
    assign wd_fire = !fu_rdy && (wd_cnt == WD_LAST);

    always_comb begin
        state_nxt = state;
        fifo_pop  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (fu_rdy || wd_fire) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Issue registers change only on a pop, so the unit operands stay put from ISSUE through RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iss_op     <= 1'b0;
            iss_a      <= '0;
            iss_b      <= '0;
            iss_tag    <= '0;
            wd_cnt     <= '0;
            rsp_result <= '0;
            rsp_tag    <= '0;
            rsp_err    <= 1'b0;
        end else begin
            if (fifo_pop) begin
                iss_op  <= head_op;
                iss_a   <= head_a;
                iss_b   <= head_b;
                iss_tag <= head_tag;
            end
            if (state == ST_ISSUE) begin
                wd_cnt <= '0;
            end else if (state == ST_WAIT) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            // fu_rdy is only looked at in WAIT, so level-held or stale strobes elsewhere are harmless.
            if (state == ST_WAIT) begin
                if (fu_rdy) begin
                    rsp_result <= fu_result;
                    rsp_tag    <= iss_tag;
                    rsp_err    <= 1'b0;
                end else if (wd_fire) begin
                    rsp_result <= FP_QNAN;
                    rsp_tag    <= iss_tag;
                    rsp_err    <= 1'b1;
                end
            end
        end
    end

    assign fu_dval   = (state == ST_ISSUE);
    assign rsp_valid = (state == ST_RESP);
    assign fu_op     = iss_op;
    assign fu_din1   = iss_a;
    assign fu_din2   = iss_b;
    assign busy      = (state != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_fpu_sp_issue.sv
module tb_fpu_sp_issue;
    import fpu_sp_pkg::*;

    localparam int DEPTH   = 4;
    localparam int TAG_W   = 4;
    localparam int TIMEOUT = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             req_valid, req_ready, req_op;
    logic [31:0]      req_a, req_b;
    logic [TAG_W-1:0] req_tag;
    logic             rsp_valid, rsp_ready, rsp_err;
    logic [31:0]      rsp_result;
    logic [TAG_W-1:0] rsp_tag;
    logic             fu_dval, fu_op, fu_rdy, busy;
    logic [31:0]      fu_din1, fu_din2, fu_result;

    fpu_sp_issue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_tag(rsp_tag), .rsp_err(rsp_err),
        .fu_dval(fu_dval), .fu_op(fu_op), .fu_din1(fu_din1), .fu_din2(fu_din2),
        .fu_result(fu_result), .fu_rdy(fu_rdy), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0]      res;
        logic [TAG_W-1:0] tag;
        logic             err;
    } exp_t;

    exp_t exp_q[$];
    int   lat_q[$];

    // Unit model state and observations
    bit          fu_hold = 0;
    int          dval_cnt = 0, dval_dbl = 0, rdy_fire = 0, rsp_count = 0;
    bit          dval_prev = 0, saw_full = 0;
    logic        seen_op;
    logic [31:0] seen_a, seen_b;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic bound_fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired, got no event, expected one", nm);
    endtask

    // Stand-in for the arithmetic unit: exact IEEE results for the directed operands,
    // NaN propagation, and an arbitrary but deterministic word otherwise.
    function automatic logic [31:0] fu_model(input logic op, input logic [31:0] a, input logic [31:0] b);
        if (op == OP_ADD && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        if (op == OP_SUB && a == 32'h422E3333 && b == 32'h428A3D71) return 32'hC1CC8F5E;
        if (op == OP_SUB && a == 32'h40A00000 && b == 32'h3F800000) return 32'h40800000;
        if (op == OP_ADD && a == 32'h00000001 && b == 32'h00000001) return 32'h00000002;
        if (a[30:23] == 8'hFF && a[22:0] != 0) return a | 32'h00400000;
        if (b[30:23] == 8'hFF && b[22:0] != 0) return b | 32'h00400000;
        return a ^ {b[15:0], b[31:16]} ^ {op, 31'b0};
    endfunction

    // Behavioural unit: rdy rises 'lat' cycles after the dval cycle (lat 0 = never).
    // In hold mode rdy stays high until the cycle after the next dval.
    initial begin : unit_model
        int          cnt;
        int          lat;
        bit          pend;
        bit          clr;
        logic [31:0] res;
        cnt = 0; lat = 0; pend = 0; clr = 0; res = 0;
        fu_rdy = 1'b0;
        fu_result = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (fu_dval) begin
                dval_cnt++;
                if (dval_prev) dval_dbl++;
                lat = (lat_q.size() > 0) ? lat_q.pop_front() : 1;
                pend = (lat != 0);
                cnt = lat;
                res = fu_model(fu_op, fu_din1, fu_din2);
                seen_op = fu_op;
                seen_a = fu_din1;
                seen_b = fu_din2;
                if (!fu_hold) fu_rdy = 1'b0;
                clr = 1;
            end else begin
                if (!fu_hold || clr) fu_rdy = 1'b0;
                clr = 0;
                if (pend) begin
                    cnt--;
                    if (cnt == 0) begin
                        fu_rdy = 1'b1;
                        fu_result = res;
                        pend = 0;
                        rdy_fire++;
                    end
                end
            end
            if (!fu_rdy) fu_result = $urandom;
            dval_prev = fu_dval;
        end
    end

    // Response scoreboard and stall-stability monitor, sampled mid-cycle.
    initial begin : monitor
        bit               stall_prev;
        logic [31:0]      p_res;
        logic [TAG_W-1:0] p_tag;
        logic             p_err;
        exp_t             e;
        stall_prev = 0; p_res = 0; p_tag = 0; p_err = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 0;
            end else begin
                if (!req_ready) saw_full = 1;
                if (stall_prev) begin
                    chk("stall_valid", rsp_valid, 1'b1);
                    chk("stall_result", rsp_result, p_res);
                    chk("stall_tag", rsp_tag, p_tag);
                    chk("stall_err", rsp_err, p_err);
                end
                if (rsp_valid && rsp_ready) begin
                    rsp_count++;
                    if (exp_q.size() == 0) begin
                        bound_fail("unexpected_response");
                    end else begin
                        e = exp_q.pop_front();
                        chk("sb_result", rsp_result, e.res);
                        chk("sb_tag", rsp_tag, e.tag);
                        chk("sb_err", rsp_err, e.err);
                    end
                end
                stall_prev = rsp_valid && !rsp_ready;
                p_res = rsp_result;
                p_tag = rsp_tag;
                p_err = rsp_err;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the handshake edge.
    task automatic send(input logic op, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] tag, input int lat, output int hs);
        exp_t e;
        req_valid = 1'b1;
        req_op = op;
        req_a = a;
        req_b = b;
        req_tag = tag;
        hs = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (req_ready) begin
                hs = cyc;
                e.err = (lat == 0) || (lat > TIMEOUT);
                e.res = e.err ? FP_QNAN : fu_model(op, a, b);
                e.tag = tag;
                exp_q.push_back(e);
                lat_q.push_back(lat);
                break;
            end
        end
        if (hs < 0) bound_fail("send_accept");
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cy);
        cy = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                cy = cyc;
                break;
            end
        end
        if (cy < 0) bound_fail("wait_rsp_valid");
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string nm);
        bit done;
        done = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !rsp_valid && !busy) begin
                done = 1;
                break;
            end
        end
        if (!done) bound_fail(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string when);
        chk({when, "_req_ready"}, req_ready, 1'b1);
        chk({when, "_rsp_valid"}, rsp_valid, 1'b0);
        chk({when, "_rsp_result"}, rsp_result, 32'h0);
        chk({when, "_rsp_tag"}, rsp_tag, 32'h0);
        chk({when, "_rsp_err"}, rsp_err, 1'b0);
        chk({when, "_fu_dval"}, fu_dval, 1'b0);
        chk({when, "_fu_op"}, fu_op, 1'b0);
        chk({when, "_fu_din1"}, fu_din1, 32'h0);
        chk({when, "_fu_din2"}, fu_din2, 32'h0);
        chk({when, "_busy"}, busy, 1'b0);
    endtask

    typedef struct {
        logic             op;
        logic [31:0]      a;
        logic [31:0]      b;
        logic [TAG_W-1:0] tag;
        int               lat;
        bit               hold;
        logic [31:0]      exp_res;
        logic             exp_err;
        int               exp_lat;
    } vec_t;

    vec_t vecs[8];

    initial begin : global_guard
        #600000;
        $display("FAIL global_timeout: simulation ran past its time limit");
        $fatal(1, "global timeout");
    end

    initial begin : main
        int hs, cy, d0, r0, n0, vcount;
        logic [31:0] a, b;

        req_valid = 0; req_op = 0; req_a = 0; req_b = 0; req_tag = 0; rsp_ready = 1;

        // op, a, b, tag, lat, hold, expected result, err, handshake-to-valid cycles
        vecs[0] = '{OP_ADD, 32'h3F800000, 32'h40000000, 4'h5, 1, 0, 32'h40400000, 1'b0, 4};
        vecs[1] = '{OP_SUB, 32'h422E3333, 32'h428A3D71, 4'h9, 4, 0, 32'hC1CC8F5E, 1'b0, 7};
        vecs[2] = '{OP_ADD, 32'h7F800000, 32'hFFC00001, 4'h3, 2, 1, 32'hFFC00001, 1'b0, 5};
        vecs[3] = '{OP_ADD, 32'h00000001, 32'h00000001, 4'h6, 3, 1, 32'h00000002, 1'b0, 6};
        vecs[4] = '{OP_ADD, 32'h12345678, 32'h9ABCDEF0, 4'hE, 8, 0, 32'hCCC4CCC4, 1'b0, 11};
        vecs[5] = '{OP_SUB, 32'h12345678, 32'h9ABCDEF0, 4'h7, 9, 0, 32'h7FC00000, 1'b1, 11};
        vecs[6] = '{OP_ADD, 32'h00000000, 32'h00000000, 4'h0, 0, 0, 32'h7FC00000, 1'b1, 11};
        vecs[7] = '{OP_SUB, 32'h40A00000, 32'h3F800000, 4'hF, 3, 0, 32'h40800000, 1'b0, 6};

        #1 rst = 1;
        #1 check_reset("por");
        repeat (3) @(posedge clk);
        #1 rst = 0;

        // Directed vectors, one request in flight at a time
        for (int i = 0; i < 8; i++) begin
            fu_hold = vecs[i].hold;
            d0 = dval_cnt;
            send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, vecs[i].lat, hs);
            wait_valid(cy);
            chk($sformatf("vec%0d_latency", i), cy - hs, vecs[i].exp_lat);
            chk($sformatf("vec%0d_result", i), rsp_result, vecs[i].exp_res);
            chk($sformatf("vec%0d_tag", i), rsp_tag, vecs[i].tag);
            chk($sformatf("vec%0d_err", i), rsp_err, vecs[i].exp_err);
            chk($sformatf("vec%0d_fu_op", i), seen_op, vecs[i].op);
            chk($sformatf("vec%0d_fu_din1", i), seen_a, vecs[i].a);
            chk($sformatf("vec%0d_fu_din2", i), seen_b, vecs[i].b);
            chk($sformatf("vec%0d_dval_count", i), dval_cnt - d0, 1);
        end
        fu_hold = 0;
        wait_drain("drain_vectors");
        chk("dval_single_cycle", dval_dbl, 0);

        // Burst of five into a four-deep FIFO, unit latency 6
        saw_full = 0; d0 = dval_cnt; n0 = rsp_count;
        for (int i = 0; i < 5; i++) begin
            send(i[0], $urandom, $urandom, 4'(i + 1), 6, hs);
        end
        wait_drain("drain_burst");
        chk("burst_saw_full", saw_full, 1'b1);
        chk("burst_dval_count", dval_cnt - d0, 5);
        chk("burst_rsp_count", rsp_count - n0, 5);

        // Backpressure: response held for 10+ cycles while the FIFO fills
        rsp_ready = 0;
        send(OP_SUB, 32'hC0000000, 32'h3F000000, 4'h1, 2, hs);
        wait_valid(cy);
        d0 = dval_cnt;
        for (int i = 0; i < 4; i++) begin
            send(OP_ADD, $urandom, $urandom, 4'(i + 2), 2, hs);
        end
        req_valid = 1; req_op = OP_ADD; req_a = 32'h3F800000; req_b = 32'h3F800000; req_tag = 4'h6;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_req_ready_full", req_ready, 1'b0);
        end
        chk("bp_rsp_valid_held", rsp_valid, 1'b1);
        chk("bp_no_new_dval", dval_cnt - d0, 0);
        @(posedge clk);
        #1 rsp_ready = 1;
        send(OP_ADD, 32'h3F800000, 32'h3F800000, 4'h6, 2, hs);
        wait_drain("drain_backpressure");

        // Randomized traffic with random response backpressure and occasional timeouts
        n0 = rsp_count;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    a = $urandom;
                    b = $urandom;
                    send(1'($urandom_range(0, 1)), a, b, 4'($urandom_range(0, 15)),
                         $urandom_range(1, TIMEOUT + 1), hs);
                    repeat ($urandom_range(0, 3)) begin
                        @(posedge clk);
                        #1;
                    end
                end
            end
            begin
                for (int i = 0; i < 1500; i++) begin
                    @(posedge clk);
                    #1 rsp_ready = 1'($urandom_range(0, 1));
                end
                rsp_ready = 1;
            end
        join
        wait_drain("drain_random");
        chk("random_rsp_count", rsp_count - n0, 40);

        // Reset while waiting on the unit with two requests queued
        rsp_ready = 1;
        send(OP_ADD, 32'h11111111, 32'h22222222, 4'hA, 20, hs);
        send(OP_ADD, 32'h33333333, 32'h44444444, 4'hB, 20, hs);
        send(OP_SUB, 32'h55555555, 32'h66666666, 4'hC, 20, hs);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("pre_reset_busy", busy, 1'b1);
        chk("pre_reset_fu_din1", fu_din1, 32'h11111111);
        d0 = dval_cnt; r0 = rdy_fire;
        rst = 1;
        exp_q.delete();
        lat_q.delete();
        #1 check_reset("mid_reset");
        repeat (2) @(posedge clk);
        #1 rst = 0;
        vcount = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (rsp_valid) vcount++;
        end
        chk("post_reset_no_rsp", vcount, 0);
        chk("post_reset_no_dval", dval_cnt - d0, 0);
        chk("post_reset_late_rdy_seen", rdy_fire - r0, 1);
        chk("post_reset_busy", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
